// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a single-byte holding register.
// Mid-bit sampling; the baud counter restarts at every sample instant so no error accumulates across a frame.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       read_req,
    output logic [7:0] read_data,
    output logic       read_data_valid,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             sample_tick;
    logic             stop_done;

    assign rx_s = sync2_q;

    // Start bit is checked half a bit in; every later sample is one full bit after the previous one.
    always_comb begin
        sample_tick = 1'b0;
        case (state_q)
            START:      sample_tick = (baud_cnt_q == HALF_LAST);
            DATA, STOP: sample_tick = (baud_cnt_q == FULL_LAST);
            default:    sample_tick = 1'b0;
        endcase
    end

    assign stop_done = (state_q == STOP) && sample_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s) state_d = START;
            START:     if (sample_tick) state_d = rx_s ? IDLE : DATA;
            DATA:      if (sample_tick && bit_cnt_q == 3'd7) state_d = STOP;
            STOP:      if (sample_tick) state_d = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        if (state_q == IDLE || state_q == WAIT_IDLE || sample_tick) begin
            baud_cnt_d = '0;
        end
        if (state_q == IDLE) begin
            bit_cnt_d = 3'd0;
        end
        if (state_q == DATA && sample_tick) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    // Holding register and status pulses; a read in the completion cycle absorbs the would-be overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = stop_done && !rx_s;
        ovr_d   = 1'b0;
        if (stop_done && rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !read_req;
        end else if (read_req) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign read_data       = data_q;
    assign read_data_valid = valid_q;
    assign framing_error   = ferr_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       read_req = 1'b0;
    logic [7:0] read_data;
    logic       read_data_valid;
    logic       framing_error;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;
    int rise_cyc = -1;
    int ferr_cyc = -1;
    int tx_start = 0;
    logic prev_valid = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .read_req        (read_req),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .framing_error   (framing_error),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (framing_error) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (framing_error && overrun) both_cnt = both_cnt + 1;
        if (read_data_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = read_data_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One full 8N1 frame on the line, bit-aligned to falling clock edges.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        tx_start = cyc;
        rx = 1'b0;
        repeat (C - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (C - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop_bit;
        repeat (C - 1) @(negedge clk);
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        rise_cyc = -1;
        ferr_cyc = -1;
    endtask

    task automatic do_read();
        @(negedge clk);
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_eq("reset_data",  read_data, 8'h00);
        check_eq("reset_valid", read_data_valid, 1'b0);
        check_eq("reset_ferr",  framing_error, 1'b0);
        check_eq("reset_ovr",   overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        clear_counts();

        // Clean 0x55: valid rises 2 sync cycles + H + 9C + 1 after rx falls.
        send_byte(8'h55, 1'b1);
        idle(20);
        check_eq("f55_data",  read_data, 8'h55);
        check_eq("f55_valid", read_data_valid, 1'b1);
        check_eq("f55_rise",  rise_cyc, tx_start + 2 + 8 + 9 * C + 1);
        check_eq("f55_ferr",  ferr_cnt, 0);
        check_eq("f55_ovr",   ovr_cnt, 0);
        do_read();
        check_eq("read_clears_valid", read_data_valid, 1'b0);
        check_eq("read_keeps_data",   read_data, 8'h55);
        do_read();
        check_eq("read_when_empty", read_data_valid, 1'b0);

        // Short low glitch on the line is rejected.
        clear_counts();
        @(negedge clk);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check_eq("glitch_valid", read_data_valid, 1'b0);
        check_eq("glitch_data",  read_data, 8'h55);
        check_eq("glitch_ferr",  ferr_cnt, 0);
        check_eq("glitch_ovr",   ovr_cnt, 0);

        // 0xA3 with a low stop bit and a held break, then a good 0x3C.
        clear_counts();
        send_byte(8'hA3, 1'b0);
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(20);
        check_eq("fe_count", ferr_cnt, 1);
        check_eq("fe_cycle", ferr_cyc, tx_start + 2 + 8 + 9 * C + 1);
        check_eq("fe_valid", read_data_valid, 1'b0);
        check_eq("fe_data",  read_data, 8'h55);
        send_byte(8'h3C, 1'b1);
        idle(20);
        check_eq("after_fe_data",  read_data, 8'h3C);
        check_eq("after_fe_valid", read_data_valid, 1'b1);
        check_eq("after_fe_ferr",  ferr_cnt, 1);
        do_read();

        // Back-to-back 0x11, 0x22 with no read: one overrun.
        clear_counts();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(20);
        check_eq("ovr_count", ovr_cnt, 1);
        check_eq("ovr_data",  read_data, 8'h22);
        check_eq("ovr_valid", read_data_valid, 1'b1);
        do_read();

        // 0x11 pending, read issued in the exact completion cycle of 0x7E.
        clear_counts();
        send_byte(8'h11, 1'b1);
        idle(10);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                repeat (2 + 8 + 9 * C + 1) @(negedge clk);
                read_req = 1'b1;
                @(negedge clk);
                read_req = 1'b0;
            end
        join
        idle(20);
        check_eq("rdsame_data",  read_data, 8'h7E);
        check_eq("rdsame_valid", read_data_valid, 1'b1);
        check_eq("rdsame_ovr",   ovr_cnt, 0);
        do_read();

        // Reset during bit 4 of 0xF0, then 0x0F.
        clear_counts();
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (5 * C + 8) @(negedge clk);
                reset = 1'b1;
                idle(2);
                reset = 1'b0;
            end
        join
        idle(20);
        check_eq("abort_valid", read_data_valid, 1'b0);
        check_eq("abort_data",  read_data, 8'h00);
        check_eq("abort_ferr",  ferr_cnt, 0);
        send_byte(8'h0F, 1'b1);
        idle(20);
        check_eq("post_rst_data",  read_data, 8'h0F);
        check_eq("post_rst_valid", read_data_valid, 1'b1);
        check_eq("never_both",     both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
